// File: rtl/store_write_controller_pkg.sv
// rtl/store_write_controller_pkg.sv - store type encodings, FSM states and lane mask helper
package store_write_controller_pkg;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SB   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SW   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BEAT0,
        S_BEAT1
    } state_t;

    // Unshifted byte mask for a store of the given type.
    function automatic logic [3:0] lane_mask(input logic [1:0] st_type);
        case (st_type)
            ST_SB:   lane_mask = 4'b0001;
            ST_SH:   lane_mask = 4'b0011;
            ST_SW:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// rtl/store_lane_gen.sv - combinational byte-enable and lane-shifted data for one write beat
module store_lane_gen
    import store_write_controller_pkg::*;
(
    input  logic [1:0]  st_type,
    input  logic [1:0]  off,
    input  logic        beat,
    input  logic [31:0] data_in,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        crosses
);

    logic [3:0]  mask;
    logic [31:0] masked;
    logic [7:0]  be_wide;
    logic [63:0] data_wide;

    // The shifted store is viewed as a two-word window: low half is beat 0, high half beat 1.
    always_comb begin
        mask      = lane_mask(st_type);
        masked    = data_in & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        be_wide   = {4'b0000, mask} << off;
        data_wide = {32'h0, masked} << {off, 3'b000};
        be        = beat ? be_wide[7:4] : be_wide[3:0];
        wdata     = beat ? data_wide[63:32] : data_wide[31:0];
        crosses   = |be_wide[7:4];
    end

endmodule

// File: rtl/store_write_controller.sv
// rtl/store_write_controller.sv - sequences MEM-stage stores into word-aligned req/ack write beats
module store_write_controller
    import store_write_controller_pkg::*;
#(
    parameter bit MISALIGN_SPLIT = 1'b1,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    input  logic [1:0]        StoreType,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       WriteData,
    output logic              st_ready,
    output logic              st_done,
    output logic              misalign_err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack
);

    state_t            state, next_state;
    logic [1:0]        cap_type;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_data;

    logic              in_idle;
    logic [1:0]        lg_type;
    logic [1:0]        lg_off;
    logic [31:0]       lg_data;
    logic              lg_beat;
    logic [3:0]        lg_be;
    logic [31:0]       lg_wdata;
    logic              lg_cross;

    logic              accept_store;
    logic              to_beat1;
    logic              finish;
    logic              misalign;

    // In IDLE the lane generator evaluates the incoming store (beat 0); while busy it
    // evaluates beat 1 of the captured store so the second beat is ready on the first ack.
    assign in_idle = (state == S_IDLE);
    assign lg_type = in_idle ? StoreType       : cap_type;
    assign lg_off  = in_idle ? st_addr[1:0]    : cap_addr[1:0];
    assign lg_data = in_idle ? WriteData       : cap_data;
    assign lg_beat = ~in_idle;

    store_lane_gen u_lane_gen (
        .st_type (lg_type),
        .off     (lg_off),
        .beat    (lg_beat),
        .data_in (lg_data),
        .be      (lg_be),
        .wdata   (lg_wdata),
        .crosses (lg_cross)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        st_ready     = 1'b0;
        accept_store = 1'b0;
        to_beat1     = 1'b0;
        finish       = 1'b0;
        misalign     = 1'b0;
        case (state)
            S_IDLE: begin
                st_ready = 1'b1;
                if (st_valid && StoreType != ST_NONE) begin
                    if (!MISALIGN_SPLIT && lg_cross) begin
                        misalign = 1'b1;
                    end else begin
                        accept_store = 1'b1;
                        next_state   = S_BEAT0;
                    end
                end
            end
            S_BEAT0: begin
                if (mem_ack) begin
                    if (lg_cross) begin
                        to_beat1   = 1'b1;
                        next_state = S_BEAT1;
                    end else begin
                        finish     = 1'b1;
                        next_state = S_IDLE;
                    end
                end
            end
            S_BEAT1: begin
                if (mem_ack) begin
                    finish     = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_done      <= 1'b0;
            misalign_err <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'h0;
            mem_be       <= 4'b0000;
            cap_type     <= ST_NONE;
            cap_addr     <= '0;
            cap_data     <= 32'h0;
        end else begin
            st_done      <= finish;
            misalign_err <= misalign;
            if (accept_store) begin
                cap_type  <= StoreType;
                cap_addr  <= st_addr;
                cap_data  <= WriteData;
                mem_req   <= 1'b1;
                mem_addr  <= {st_addr[ADDR_W-1:2], 2'b00};
                mem_be    <= lg_be;
                mem_wdata <= lg_wdata;
            end else if (to_beat1) begin
                mem_addr  <= mem_addr + ADDR_W'(4);
                mem_be    <= lg_be;
                mem_wdata <= lg_wdata;
            end else if (finish) begin
                mem_req   <= 1'b0;
                mem_be    <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_store_write_controller.sv
// tb/tb_store_write_controller.sv - directed self-checking bench for store_write_controller
module tb_store_write_controller;

    logic        clk;
    logic        reset;
    logic [1:0]  StoreType;
    logic [31:0] st_addr;
    logic [31:0] WriteData;

    logic        st_valid_a, mem_ack_a;
    logic        st_ready_a, st_done_a, misalign_err_a, mem_req_a;
    logic [31:0] mem_addr_a, mem_wdata_a;
    logic [3:0]  mem_be_a;

    logic        st_valid_b, mem_ack_b;
    logic        st_ready_b, st_done_b, misalign_err_b, mem_req_b;
    logic [31:0] mem_addr_b, mem_wdata_b;
    logic [3:0]  mem_be_b;

    int tests_run;
    int tests_failed;

    store_write_controller #(.MISALIGN_SPLIT(1'b1), .ADDR_W(32)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .st_valid     (st_valid_a),
        .StoreType    (StoreType),
        .st_addr      (st_addr),
        .WriteData    (WriteData),
        .st_ready     (st_ready_a),
        .st_done      (st_done_a),
        .misalign_err (misalign_err_a),
        .mem_req      (mem_req_a),
        .mem_addr     (mem_addr_a),
        .mem_wdata    (mem_wdata_a),
        .mem_be       (mem_be_a),
        .mem_ack      (mem_ack_a)
    );

    store_write_controller #(.MISALIGN_SPLIT(1'b0), .ADDR_W(32)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .st_valid     (st_valid_b),
        .StoreType    (StoreType),
        .st_addr      (st_addr),
        .WriteData    (WriteData),
        .st_ready     (st_ready_b),
        .st_done      (st_done_b),
        .misalign_err (misalign_err_b),
        .mem_req      (mem_req_b),
        .mem_addr     (mem_addr_b),
        .mem_wdata    (mem_wdata_b),
        .mem_be       (mem_be_b),
        .mem_ack      (mem_ack_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic present_a(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        st_valid_a = 1'b1;
        StoreType  = t;
        st_addr    = a;
        WriteData  = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({mem_req_a, mem_be_a, mem_addr_a, mem_wdata_a} !== {1'b0, 4'h0, 32'h0, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got req=%0b be=%b addr=%h wdata=%h, want all zero", mem_req_a, mem_be_a, mem_addr_a, mem_wdata_a);
        end
        tests_run++;
        if ({st_ready_a, st_done_a, misalign_err_a} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_status: got ready/done/err=%b, want 100", {st_ready_a, st_done_a, misalign_err_a});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sw_aligned();
        mem_ack_a = 1'b1;
        present_a(2'b11, 32'h100, 32'hDEADBEEF);
        tests_run++;
        if (st_ready_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL sw_ready_idle: got %0b want 1", st_ready_a);
        end
        @(negedge clk);
        st_valid_a = 1'b0;
        tests_run++;
        if ({st_ready_a, mem_req_a, mem_addr_a, mem_be_a, mem_wdata_a, st_done_a} !== {1'b0, 1'b1, 32'h100, 4'b1111, 32'hDEADBEEF, 1'b0}) begin
            tests_failed++;
            $display("FAIL sw_beat0: got ready=%0b req=%0b addr=%h be=%b wdata=%h done=%0b, want 0 1 00000100 1111 deadbeef 0",
                     st_ready_a, mem_req_a, mem_addr_a, mem_be_a, mem_wdata_a, st_done_a);
        end
        @(negedge clk);
        tests_run++;
        if ({st_done_a, mem_req_a, mem_be_a, st_ready_a} !== {1'b1, 1'b0, 4'b0000, 1'b1}) begin
            tests_failed++;
            $display("FAIL sw_done: got done=%0b req=%0b be=%b ready=%0b, want 1 0 0000 1", st_done_a, mem_req_a, mem_be_a, st_ready_a);
        end
        @(negedge clk);
        tests_run++;
        if (st_done_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL sw_done_pulse: got %0b want 0", st_done_a);
        end
    endtask

    task automatic test_sb_top_lane();
        mem_ack_a = 1'b1;
        present_a(2'b01, 32'h103, 32'hFFFFFFAB);
        @(negedge clk);
        st_valid_a = 1'b0;
        tests_run++;
        if ({mem_req_a, mem_addr_a, mem_be_a, mem_wdata_a} !== {1'b1, 32'h100, 4'b1000, 32'hAB000000}) begin
            tests_failed++;
            $display("FAIL sb_beat0: got req=%0b addr=%h be=%b wdata=%h, want 1 00000100 1000 ab000000", mem_req_a, mem_addr_a, mem_be_a, mem_wdata_a);
        end
        @(negedge clk);
        tests_run++;
        if ({st_done_a, mem_req_a, mem_be_a} !== {1'b1, 1'b0, 4'b0000}) begin
            tests_failed++;
            $display("FAIL sb_single_beat: got done=%0b req=%0b be=%b, want 1 0 0000", st_done_a, mem_req_a, mem_be_a);
        end
        @(negedge clk);
    endtask

    task automatic test_sh_split();
        mem_ack_a = 1'b1;
        present_a(2'b10, 32'h203, 32'h00001234);
        @(negedge clk);
        st_valid_a = 1'b0;
        tests_run++;
        if ({mem_req_a, mem_addr_a, mem_be_a, mem_wdata_a, st_done_a} !== {1'b1, 32'h200, 4'b1000, 32'h34000000, 1'b0}) begin
            tests_failed++;
            $display("FAIL sh_beat0: got req=%0b addr=%h be=%b wdata=%h done=%0b, want 1 00000200 1000 34000000 0",
                     mem_req_a, mem_addr_a, mem_be_a, mem_wdata_a, st_done_a);
        end
        @(negedge clk);
        tests_run++;
        if ({mem_req_a, mem_addr_a, mem_be_a, mem_wdata_a, st_done_a, st_ready_a} !== {1'b1, 32'h204, 4'b0001, 32'h00000012, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL sh_beat1: got req=%0b addr=%h be=%b wdata=%h done=%0b ready=%0b, want 1 00000204 0001 00000012 0 0",
                     mem_req_a, mem_addr_a, mem_be_a, mem_wdata_a, st_done_a, st_ready_a);
        end
        @(negedge clk);
        tests_run++;
        if ({st_done_a, mem_req_a, mem_be_a} !== {1'b1, 1'b0, 4'b0000}) begin
            tests_failed++;
            $display("FAIL sh_done: got done=%0b req=%0b be=%b, want 1 0 0000", st_done_a, mem_req_a, mem_be_a);
        end
        @(negedge clk);
    endtask

    task automatic test_sw_split_wait();
        mem_ack_a = 1'b0;
        present_a(2'b11, 32'h301, 32'h11223344);
        @(negedge clk);
        st_valid_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({st_ready_a, mem_req_a, mem_addr_a, mem_be_a, mem_wdata_a} !== {1'b0, 1'b1, 32'h300, 4'b1110, 32'h22334400}) begin
                tests_failed++;
                $display("FAIL swx_beat0_hold[%0d]: got ready=%0b req=%0b addr=%h be=%b wdata=%h, want 0 1 00000300 1110 22334400",
                         i, st_ready_a, mem_req_a, mem_addr_a, mem_be_a, mem_wdata_a);
            end
            if (i == 2) mem_ack_a = 1'b1;
            @(negedge clk);
        end
        mem_ack_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if ({st_ready_a, mem_req_a, mem_addr_a, mem_be_a, mem_wdata_a, st_done_a} !== {1'b0, 1'b1, 32'h304, 4'b0001, 32'h00000011, 1'b0}) begin
                tests_failed++;
                $display("FAIL swx_beat1_hold[%0d]: got ready=%0b req=%0b addr=%h be=%b wdata=%h done=%0b, want 0 1 00000304 0001 00000011 0",
                         i, st_ready_a, mem_req_a, mem_addr_a, mem_be_a, mem_wdata_a, st_done_a);
            end
            if (i == 2) mem_ack_a = 1'b1;
            @(negedge clk);
        end
        mem_ack_a = 1'b0;
        tests_run++;
        if ({st_done_a, mem_req_a, mem_be_a, st_ready_a} !== {1'b1, 1'b0, 4'b0000, 1'b1}) begin
            tests_failed++;
            $display("FAIL swx_done: got done=%0b req=%0b be=%b ready=%0b, want 1 0 0000 1", st_done_a, mem_req_a, mem_be_a, st_ready_a);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_beat1();
        mem_ack_a = 1'b1;
        present_a(2'b11, 32'h301, 32'h11223344);
        @(negedge clk);
        st_valid_a = 1'b0;
        @(negedge clk);
        mem_ack_a = 1'b1;
        tests_run++;
        if ({mem_req_a, mem_addr_a, mem_be_a} !== {1'b1, 32'h304, 4'b0001}) begin
            tests_failed++;
            $display("FAIL rst_pre_beat1: got req=%0b addr=%h be=%b, want 1 00000304 0001", mem_req_a, mem_addr_a, mem_be_a);
        end
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        mem_ack_a = 1'b0;
        tests_run++;
        if ({mem_req_a, mem_be_a, st_ready_a, st_done_a} !== {1'b0, 4'b0000, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL rst_beat1: got req=%0b be=%b ready=%0b done=%0b, want 0 0000 1 0", mem_req_a, mem_be_a, st_ready_a, st_done_a);
        end
        @(negedge clk);
        tests_run++;
        if ({st_done_a, mem_req_a} !== 2'b00) begin
            tests_failed++;
            $display("FAIL rst_no_done: got done=%0b req=%0b, want 0 0", st_done_a, mem_req_a);
        end
    endtask

    task automatic test_misalign_reject();
        mem_ack_b  = 1'b1;
        st_valid_b = 1'b1;
        StoreType  = 2'b10;
        st_addr    = 32'h003;
        WriteData  = 32'h0000BEEF;
        @(negedge clk);
        st_valid_b = 1'b0;
        tests_run++;
        if ({misalign_err_b, mem_req_b, st_ready_b} !== 3'b101) begin
            tests_failed++;
            $display("FAIL mis_pulse: got err/req/ready=%b, want 101", {misalign_err_b, mem_req_b, st_ready_b});
        end
        @(negedge clk);
        tests_run++;
        if ({misalign_err_b, mem_req_b, st_done_b} !== 3'b000) begin
            tests_failed++;
            $display("FAIL mis_after: got err/req/done=%b, want 000", {misalign_err_b, mem_req_b, st_done_b});
        end
        st_valid_b = 1'b1;
        st_addr    = 32'h002;
        @(negedge clk);
        st_valid_b = 1'b0;
        tests_run++;
        if ({misalign_err_b, mem_req_b, mem_addr_b, mem_be_b, mem_wdata_b} !== {1'b0, 1'b1, 32'h0, 4'b1100, 32'hBEEF0000}) begin
            tests_failed++;
            $display("FAIL mis_fits: got err=%0b req=%0b addr=%h be=%b wdata=%h, want 0 1 00000000 1100 beef0000",
                     misalign_err_b, mem_req_b, mem_addr_b, mem_be_b, mem_wdata_b);
        end
        @(negedge clk);
        tests_run++;
        if ({st_done_b, mem_req_b} !== 2'b10) begin
            tests_failed++;
            $display("FAIL mis_fits_done: got done=%0b req=%0b, want 1 0", st_done_b, mem_req_b);
        end
        mem_ack_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_store();
        mem_ack_a = 1'b1;
        present_a(2'b00, 32'h400, 32'h55667788);
        @(negedge clk);
        st_valid_a = 1'b0;
        tests_run++;
        if ({mem_req_a, mem_be_a, st_ready_a} !== {1'b0, 4'b0000, 1'b1}) begin
            tests_failed++;
            $display("FAIL none_req: got req=%0b be=%b ready=%0b, want 0 0000 1", mem_req_a, mem_be_a, st_ready_a);
        end
        @(negedge clk);
        tests_run++;
        if ({st_done_a, mem_req_a} !== 2'b00) begin
            tests_failed++;
            $display("FAIL none_done: got done=%0b req=%0b, want 0 0", st_done_a, mem_req_a);
        end
        mem_ack_a = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        st_valid_a   = 1'b0;
        st_valid_b   = 1'b0;
        mem_ack_a    = 1'b0;
        mem_ack_b    = 1'b0;
        StoreType    = 2'b00;
        st_addr      = 32'h0;
        WriteData    = 32'h0;
        @(negedge clk);
        test_reset();
        test_sw_aligned();
        test_sb_top_lane();
        test_sh_split();
        test_sw_split_wait();
        test_reset_in_beat1();
        test_misalign_reject();
        test_no_store();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
